// File: rtl/qr_pkg.sv
// Shared definitions for the QR index sequencer: the sweep state encoding and
// the default index width.
package qr_pkg;
  localparam int IDX_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/qr_bound_counter.sv
// Loadable up-counter with an inclusive limit. A step at the limit reloads
// load_val, so the owner can supply a different reload value for each pass.
module qr_bound_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] limit,
  output logic [W-1:0] value,
  output logic         wrap
);
  logic [W-1:0] value_q, value_d;

  assign wrap  = (value_q == limit);
  assign value = value_q;

  always_comb begin
    value_d = value_q;
    if (load)      value_d = load_val;
    else if (step) value_d = wrap ? load_val : value_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) value_q <= '0;
    else        value_q <= value_d;
  end
endmodule

// File: rtl/qr_index_sequencer.sv
// Issues (row, col) element indices for a QR sweep: column-major over the full
// matrix, or the strictly sub-diagonal elements in Givens-elimination order.
module qr_index_sequencer
  import qr_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF,
  parameter int CNT_W = 2 * IDX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [IDX_W-1:0] n_rows,
  input  logic [IDX_W-1:0] n_cols,
  input  logic             tri_mode,
  input  logic             advance,
  output logic             idx_valid,
  output logic [IDX_W-1:0] row_idx,
  output logic [IDX_W-1:0] col_idx,
  output logic             last,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count
);
  state_t           state_q, state_d;
  logic             tri_q, tri_d;
  logic [IDX_W-1:0] r_lim_q, r_lim_d;
  logic [IDX_W-1:0] c_lim_q, c_lim_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             r_wrap, c_wrap, last_w, accept, start_go, empty;
  logic [IDX_W-1:0] m_minus1, tri_cols, r_load_val;

  assign m_minus1 = n_rows - IDX_W'(1);
  assign tri_cols = (n_cols < m_minus1) ? n_cols : m_minus1;
  assign empty    = (n_rows == '0) || (n_cols == '0) || (tri_mode && (n_rows <= IDX_W'(1)));
  assign start_go = (state_q == ST_IDLE) && start && !abort;
  assign accept   = (state_q == ST_RUN) && advance;
  assign last_w   = r_wrap && c_wrap;

  // Tri mode restarts each column just below the diagonal of the next column.
  assign r_load_val = start_go ? (tri_mode ? IDX_W'(1) : '0)
                               : (tri_q ? col_idx + IDX_W'(2) : '0);

  qr_bound_counter #(.W(IDX_W)) u_row (
    .clk      (clk),
    .reset    (reset),
    .load     (start_go),
    .step     (accept && !last_w),
    .load_val (r_load_val),
    .limit    (r_lim_q),
    .value    (row_idx),
    .wrap     (r_wrap)
  );

  qr_bound_counter #(.W(IDX_W)) u_col (
    .clk      (clk),
    .reset    (reset),
    .load     (start_go),
    .step     (accept && r_wrap && !last_w),
    .load_val ('0),
    .limit    (c_lim_q),
    .value    (col_idx),
    .wrap     (c_wrap)
  );

  always_comb begin
    state_d = state_q;
    tri_d   = tri_q;
    r_lim_d = r_lim_q;
    c_lim_d = c_lim_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (start_go) begin
          tri_d   = tri_mode;
          r_lim_d = m_minus1;
          c_lim_d = tri_mode ? tri_cols - IDX_W'(1) : n_cols - IDX_W'(1);
          count_d = '0;
          state_d = empty ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept) count_d = count_q + CNT_W'(1);
        if (abort)                  state_d = ST_IDLE;
        else if (accept && last_w)  state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      tri_q   <= 1'b0;
      r_lim_q <= '0;
      c_lim_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      tri_q   <= tri_d;
      r_lim_q <= r_lim_d;
      c_lim_q <= c_lim_d;
      count_q <= count_d;
    end
  end

  assign idx_valid = (state_q == ST_RUN);
  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign last      = idx_valid && last_w;
  assign count     = count_q;
endmodule

// File: tb/tb_qr_index_sequencer.sv
// Scoreboard bench: the driver pushes the expected index list of each sweep,
// a negedge monitor compares every presented index against the queue head.
module tb_qr_index_sequencer;
  localparam int IDX_W = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset, start, abort, tri_mode, advance;
  logic [IDX_W-1:0] n_rows, n_cols;
  logic             idx_valid, last, busy, done;
  logic [IDX_W-1:0] row_idx, col_idx;
  logic [CNT_W-1:0] count;

  typedef struct {
    int r;
    int c;
    bit last;
  } idx_t;

  idx_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;
  int   last_count = 0;

  always #5 clk = ~clk;

  qr_index_sequencer #(.IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .n_rows(n_rows), .n_cols(n_cols), .tri_mode(tri_mode), .advance(advance),
    .idx_valid(idx_valid), .row_idx(row_idx), .col_idx(col_idx),
    .last(last), .busy(busy), .done(done), .count(count)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: enumerate the element set directly from the sweep rules.
  task automatic build_model(input int m, input int n, input bit t, output int len);
    idx_t lst[$];
    idx_t e;
    if (!t) begin
      for (int c = 0; c < n; c++)
        for (int r = 0; r < m; r++) begin
          e.r = r; e.c = c; e.last = 1'b0; lst.push_back(e);
        end
    end else begin
      for (int c = 0; c < n && c < m - 1; c++)
        for (int r = c + 1; r < m; r++) begin
          e.r = r; e.c = c; e.last = 1'b0; lst.push_back(e);
        end
    end
    len = lst.size();
    if (len > 0) begin
      e = lst[len-1];
      e.last = 1'b1;
      lst[len-1] = e;
    end
    foreach (lst[i]) exp_q.push_back(lst[i]);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (done) done_cnt++;
      if (idx_valid) begin
        if (exp_q.size() == 0) chk("spurious_valid", 1, 0);
        else begin
          chk("row_idx", int'(row_idx), exp_q[0].r);
          chk("col_idx", int'(col_idx), exp_q[0].c);
          chk("last", int'(last), int'(exp_q[0].last));
          if (advance) exp_q.delete(0);
        end
      end
    end
  end

  // mode: 0 = advance always, 1 = pattern 1,0,0 repeating, 2 = random.
  task automatic sweep(input int m, input int n, input bit t, input int mode, input int abort_at);
    int len, acc, cyc, ph, done0, exp_cnt;
    bit adv, aborted;
    exp_q.delete();
    build_model(m, n, t, len);
    aborted = (abort_at >= 0) && (abort_at < len);
    exp_cnt = aborted ? abort_at + 1 : len;
    done0 = done_cnt;
    @(posedge clk) #1;
    start = 1'b1; n_rows = IDX_W'(m); n_cols = IDX_W'(n); tri_mode = t; advance = 1'b0;
    @(posedge clk) #1;
    start = 1'b0;
    chk("first_valid", int'(idx_valid), int'(len > 0));
    chk("empty_done", int'(done), int'(len == 0));
    acc = 0; cyc = 0; ph = 0;
    while (idx_valid && cyc < 400) begin
      n_rows   = IDX_W'($urandom);
      n_cols   = IDX_W'($urandom);
      tri_mode = 1'($urandom);
      start    = 1'($urandom);
      adv = (mode == 0) ? 1'b1 : (mode == 1) ? (ph % 3 == 0) : 1'($urandom);
      ph++;
      advance = adv;
      abort   = adv && (acc == abort_at);
      if (adv) acc++;
      @(posedge clk) #1;
      cyc++;
    end
    start = 1'b0; advance = 1'b0; abort = 1'b0;
    if (cyc >= 400) chk("sweep_timeout", cyc, 0);
    chk("busy_after", int'(busy), 0);
    if (aborted) begin
      chk("abort_no_done", int'(done), 0);
    end else if (len > 0) begin
      chk("done_pulse", int'(done), 1);
      start = 1'b1; n_rows = 4'd3; n_cols = 4'd3; tri_mode = 1'b0;
      @(posedge clk) #1;
      start = 1'b0;
      chk("start_in_done_ignored", int'(idx_valid), 0);
    end
    repeat (2) @(posedge clk);
    #1;
    chk("done_count", done_cnt - done0, aborted ? 0 : 1);
    chk("count", int'(count), exp_cnt);
    chk("leftover", exp_q.size(), len - exp_cnt);
    last_count = exp_cnt;
    exp_q.delete();
  endtask

  initial begin
    int len;
    reset = 1'b1; start = 1'b0; abort = 1'b0; advance = 1'b0;
    tri_mode = 1'b0; n_rows = '0; n_cols = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", int'(idx_valid), 0);
    chk("rst_row", int'(row_idx), 0);
    chk("rst_col", int'(col_idx), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    reset = 1'b0;

    sweep(2, 2, 1'b0, 0, -1);
    sweep(4, 3, 1'b1, 0, -1);
    sweep(3, 1, 1'b0, 1, -1);
    sweep(1, 5, 1'b1, 0, -1);
    sweep(3, 0, 1'b0, 0, -1);
    sweep(3, 3, 1'b0, 0, 3);
    sweep(3, 2, 1'b0, 0, 5);

    // abort beats start in IDLE; count keeps the previous sweep's value
    @(posedge clk) #1;
    start = 1'b1; abort = 1'b1; n_rows = 4'd3; n_cols = 4'd3; tri_mode = 1'b0;
    @(posedge clk) #1;
    start = 1'b0; abort = 1'b0;
    chk("abort_start_valid", int'(idx_valid), 0);
    chk("abort_start_done", int'(done), 0);
    chk("abort_start_count", int'(count), last_count);

    for (int k = 0; k < 25; k++)
      sweep($urandom_range(0, 6), $urandom_range(0, 6), 1'($urandom), $urandom_range(0, 2),
            ($urandom_range(0, 3) == 0) ? $urandom_range(0, 10) : -1);

    // reset on the 4th acceptance of a 3x3 sweep
    exp_q.delete();
    build_model(3, 3, 1'b0, len);
    @(posedge clk) #1;
    start = 1'b1; n_rows = 4'd3; n_cols = 4'd3; tri_mode = 1'b0;
    @(posedge clk) #1;
    start = 1'b0; advance = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk) #1;
    chk("mid_rst_valid", int'(idx_valid), 0);
    chk("mid_rst_row", int'(row_idx), 0);
    chk("mid_rst_col", int'(col_idx), 0);
    chk("mid_rst_count", int'(count), 0);
    chk("mid_rst_last", int'(last), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    reset = 1'b0; advance = 1'b0;
    exp_q.delete();
    @(posedge clk) #1;
    chk("post_rst_valid", int'(idx_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/qr_index_sequencer.md
QR_INDEX_SEQUENCER -- requirements
Module: qr_index_sequencer

Interface
REQ-001 Parameter IDX_W, default 4, index width; maximum matrix dimension is 2^IDX_W-1.
REQ-002 Parameter CNT_W, default 2*IDX_W, width of the issued-index counter.
REQ-003 Ports: clk is input, 1 bit, the clock; all logic is on the rising edge.
REQ-004 Ports: reset is input, 1 bit, synchronous, active-high.
REQ-005 Ports: start is input, 1 bit; a one-cycle request to begin a sweep.
REQ-006 Ports: abort is input, 1 bit; terminates a sweep without done.
REQ-007 Ports: n_rows is input, IDX_W bits, row count M.
REQ-008 Ports: n_cols is input, IDX_W bits, column count N.
REQ-009 Ports: tri_mode is input, 1 bit; 1 selects the sub-diagonal sweep, 0 the full sweep.
REQ-010 Ports: advance is input, 1 bit; the consumer accepts the current index.
REQ-011 Ports: idx_valid is output, 1 bit; row_idx/col_idx are meaningful.
REQ-012 Ports: row_idx and col_idx are outputs, IDX_W bits each; the current element (r,c).
REQ-013 Ports: last is output, 1 bit; the current index is the final one of the sweep.
REQ-014 Ports: busy is output, 1 bit; high in RUN.
REQ-015 Ports: done is output, 1 bit; a one-cycle pulse at normal completion.
REQ-016 Ports: count is output, CNT_W bits; indices accepted in the current or last sweep.

Function
REQ-017 States SHALL be IDLE, RUN and DONE.
REQ-018 In IDLE, start SHALL latch n_rows, n_cols and tri_mode, clear count, and load the first index.
REQ-019 Full mode SHALL have column c as the outer loop, 0..N-1, and row r as the inner loop, 0..M-1.
REQ-020 Tri mode SHALL use c = 0..min(N,M-1)-1 and r = c+1..M-1, i.e. Givens-elimination order.
REQ-021 Start at cycle t with a non-empty set SHALL enter RUN at t+1, with idx_valid=1 and the first index presented at t+1.
REQ-022 The index SHALL advance only on a cycle where idx_valid&&advance; otherwise row_idx, col_idx and last SHALL hold.
REQ-023 On inner wrap, r SHALL reload (0 in full mode, c+1 in tri mode) and c SHALL increment in the same cycle.
REQ-024 last SHALL be high exactly while the final index is presented.
REQ-025 Acceptance of last at cycle t SHALL give DONE at t+1, with done=1, busy=0 and idx_valid=0; IDLE follows at t+2.
REQ-026 An empty set (M=0, N=0, or tri with M<=1) SHALL go IDLE to DONE directly, with done at t+1 and no idx_valid.
REQ-027 count SHALL increment by 1 per accepted index, cannot overflow, and SHALL hold its value in IDLE until the next start.
REQ-028 start SHALL be ignored in RUN and DONE; n_rows, n_cols and tri_mode changes during RUN SHALL have no effect.
REQ-029 abort in RUN SHALL return the block to IDLE next cycle with idx_valid=0 and no done pulse; count SHALL hold.
REQ-030 abort and start in the same IDLE cycle: abort SHALL win and no sweep starts.
REQ-031 Simultaneous acceptance of last and abort: abort SHALL win, count SHALL include the final index, and done SHALL stay 0.

Reset
REQ-032 reset SHALL force IDLE and drive row_idx=0, col_idx=0, count=0, idx_valid=0, last=0, busy=0 and done=0 on the next edge.
REQ-033 reset SHALL take priority over start, abort and advance, including mid-sweep.

Structure
REQ-034 The state enum typedef and the IDX_W default SHALL live in shared package qr_pkg.
REQ-035 The r and c loops SHALL each be one instance of sub-module qr_bound_counter (load value, inclusive limit, step enable, wrap flag).
REQ-036 The design SHALL contain no combinational path from advance to idx_valid.

Verification
REQ-037 Full mode, M=2, N=2, advance=1: indices (0,0),(1,0),(0,1),(1,1) on consecutive cycles; last on the 4th; done the next cycle; count=4.
REQ-038 Tri mode, M=4, N=3: indices (1,0),(2,0),(3,0),(2,1),(3,1),(3,2); count=6; one done pulse.
REQ-039 Full mode, M=3, N=1, advance toggling 1,0,0,1,...: index holds during low cycles; exactly 3 acceptances; count=3.
REQ-040 Tri mode with M=1, and separately full mode with N=0: done at t+1; idx_valid never high; count=0.
REQ-041 Full mode, M=3, N=3: reset at the 4th accept returns all outputs to 0; start in DONE is ignored.
REQ-042 Full mode, M=3, N=3: abort at the 4th accept gives no done and count=4.
